dbus_arbiter: RTL
=================

// Module: dbus_arbiter
// PURPOSE
//  Shares the single data bus (RAM + memory-mapped IO behind io_ram_decoder) between two masters:
//  m0 = CPU load/store port, m1 = UART program loader / DMA.
//  Serialises accesses, drives one address/we/wdata set into the decoder, returns read data to the
//  winning master. Sits between the masters and the decoder's address/we/load-mux data path.
// PARAMETERS
//  READ_LAT  1  cycles from address presented (ISSUE) to bus_rdata valid; legal 1..7
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  m0_req     in   1   m0 access request, level; held with m0_we/addr/wdata stable until m0_gnt
//  m0_we      in   1   1 = write, 0 = read
//  m0_addr    in   32  byte address
//  m0_wdata   in   32  write data
//  m0_gnt     out  1   1-cycle pulse: m0 access is on the bus this cycle
//  m0_rvalid  out  1   1-cycle pulse: m0_rdata valid (reads only)
//  m0_rdata   out  32  captured read data, held until next m0 read capture
//  m1_*       --   --  identical set for master 1 (m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata)
//  bus_addr   out  32  address to decoder
//  bus_we     out  1   write enable to decoder
//  bus_wdata  out  32  write data to RAM/IO
//  bus_rdata  in   32  read data from decoder load mux
//  bus_busy   out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (bus_addr/bus_wdata/m*_rdata = 32'h0); last_gnt=1 (so m0 wins first).
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  - IDLE: if any req, pick winner, register sel, bus_addr, bus_wdata and the winner's we -> ISSUE; else stay.
//  - ISSUE (1 cycle): m<sel>_gnt=1; bus_we = registered we (only cycle bus_we may be 1).
//    Write -> IDLE. Read -> WAIT with wait counter = 1.
//  - WAIT: counter increments each cycle; in cycle ISSUE+READ_LAT bus_rdata is sampled into
//    m<sel>_rdata -> RESP. For READ_LAT=1, WAIT lasts exactly one cycle.
//  - RESP (1 cycle): m<sel>_rvalid=1 -> IDLE.
//  bus_addr/bus_wdata held constant from ISSUE through the capture cycle; updated only on IDLE->ISSUE.
//  Latency: req seen in IDLE at edge k -> gnt in cycle k+1; rvalid in cycle k+READ_LAT+2.
//  Throughput: write 2 cycles/access, read READ_LAT+3 cycles/access; no overlap of accesses.
//  Requests arriving in non-IDLE states wait; they are never dropped while req is held.
//  Master may drop req in the cycle after gnt; a read master must not re-request before its rvalid.
//  Non-selected master's gnt/rvalid/rdata never change.
//  Reset mid-operation (any state): immediate return to IDLE, in-flight access discarded,
//  no gnt/rvalid emitted, bus_we forced 0 asynchronously.
//  No address decode or alignment checking here; the decoder owns that.
// CONFIGURATION
//  DBUS_ARB_RR_EN defined: round-robin; on simultaneous req in IDLE the master other than last_gnt
//    wins; last_gnt updated on every IDLE->ISSUE.
//  DBUS_ARB_RR_EN undefined: fixed priority, m0 always wins when m0_req=1; last_gnt unused (m1 may starve).
// TESTING
//  1 rst=1 mid-run -> all outputs 0, bus_busy=0; after release, first simultaneous req grants m0.
//  2 m0 write addr 32'h0000_0010 data 32'hDEAD_BEEF -> m0_gnt 1 cycle after req, bus_we=1 for exactly
//    that cycle with bus_addr/bus_wdata matching; back to IDLE next cycle.
//  3 READ_LAT=1, m1 read 32'h0040_0004, bus_rdata=32'h0000_0003 in capture cycle -> m1_rvalid 1 cycle
//    after capture, m1_rdata=32'h3; m0 outputs unchanged.
//  4 Both req held, 3 reads each -> with DBUS_ARB_RR_EN gnt order m0,m1,m0,m1,m0,m1;
//    without it m0,m0,m0 then m1 after m0_req drops.
//  5 rst asserted during WAIT of an m0 read -> no m0_rvalid ever, bus_we=0, state IDLE.
//  6 READ_LAT=3 -> bus_addr stable 4 cycles (ISSUE..capture), rvalid at req-edge+5 cycles, data correct.

Source files
------------

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter in front of the RAM/IO decoder; one access in flight at a time.
// Define DBUS_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module dbus_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        bus_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_C = 3'(READ_LAT);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        sel_r;
  logic        we_r;
  logic [2:0]  wait_cnt_r;
  logic        any_req_s;
  logic        win_s;
  logic        capture_s;
`ifdef DBUS_ARB_RR_EN
  logic        last_gnt_r;
`endif

  // Winner selection among the currently requesting masters
  always_comb begin
    any_req_s = m0_req | m1_req;
`ifdef DBUS_ARB_RR_EN
    if (m0_req && m1_req) begin
      win_s = ~last_gnt_r;
    end else begin
      win_s = ~m0_req;
    end
`else
    win_s = ~m0_req;
`endif
  end

  assign capture_s = (state_r == ST_WAIT) && (wait_cnt_r == LAT_C);

  // State register; reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (we_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (capture_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: strobes come straight from registered state, so reset clears them at once
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    bus_we    = 1'b0;
    bus_busy  = (state_r != ST_IDLE);
    case (state_r)
      ST_ISSUE: begin
        if (sel_r) begin
          m1_gnt = 1'b1;
        end else begin
          m0_gnt = 1'b1;
        end
        bus_we = we_r;
      end
      ST_RESP: begin
        if (sel_r) begin
          m1_rvalid = 1'b1;
        end else begin
          m0_rvalid = 1'b1;
        end
      end
      default: begin
        bus_we = 1'b0;
      end
    endcase
  end

  // Access latch on IDLE->ISSUE, wait counter and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r      <= 1'b0;
      we_r       <= 1'b0;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
      wait_cnt_r <= 3'd0;
      m0_rdata   <= 32'h0;
      m1_rdata   <= 32'h0;
    end else begin
      if ((state_r == ST_IDLE) && any_req_s) begin
        sel_r     <= win_s;
        we_r      <= win_s ? m1_we    : m0_we;
        bus_addr  <= win_s ? m1_addr  : m0_addr;
        bus_wdata <= win_s ? m1_wdata : m0_wdata;
      end
      if (state_r == ST_ISSUE) begin
        wait_cnt_r <= 3'd1;
      end else if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r + 3'd1;
      end
      if (capture_s) begin
        if (sel_r) begin
          m1_rdata <= bus_rdata;
        end else begin
          m0_rdata <= bus_rdata;
        end
      end
    end
  end

`ifdef DBUS_ARB_RR_EN
  // Remember the last winner so simultaneous requests alternate; m0 wins first after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && any_req_s) begin
      last_gnt_r <= win_s;
    end
  end
`endif

endmodule
